light_fader: RTL and testbench
==============================

Name: light_fader

Overview:
- Downstream output stage for the 8-bit LED pattern generator.
- Takes the raw on/off pattern and drives the physical LEDs with per-channel PWM brightness.
- Each LED fades up toward a global brightness ceiling when its input bit is 1, and fades down to 0 when the bit is 0.
- Runs on the same 100 kHz system clock as the pattern generator; sits between the generator and the board LED pins.

Parameters:
- N_LED, 8, number of LED channels.
- STEP_DIV, 625, clk100khz cycles per brightness step (6.25 ms/step at 100 kHz); must be >= 2.

Ports:
- clk100khz  input   1      system clock, 100 kHz.
- rst        input   1      reset, asynchronous, active-high.
- light_in   input   N_LED  raw pattern from generator; asynchronous to fade timing and may change any cycle.
- bright_max input   4      global ceiling level, 0..15; sampled every cycle.
- led_out    output  N_LED  PWM-modulated LED drive, registered.
- busy       output  1      1 while any channel level differs from its target, registered.

Behaviour:
- Reset (async, active-high):
  - All channel levels, pwm_cnt, step prescaler, synchronizer flops, led_out and busy go to 0.
  - Release is synchronous to the next clk100khz edge.
- Input sync:
  - light_in passes through a 2-flop synchronizer to give light_s.
  - Latency is 2 cycles from light_in to light_s.
- PWM counter:
  - pwm_cnt is 4 bits and counts 0..14, then wraps to 0, giving a period of 15 cycles.
- PWM output:
  - led_out[i] <= (level[i] > pwm_cnt), registered, 1-cycle latency.
  - Level 0 gives constant off.
  - Level 15 gives constant on.
  - Level k gives exactly k high cycles per 15-cycle period.
- Step prescaler:
  - Counts 0..STEP_DIV-1.
  - step_tick is asserted for 1 cycle when the count equals STEP_DIV-1, then the count wraps to 0.
- Per-channel target:
  - target[i] = light_s[i] ? bright_max : 0.
- Level update, on step_tick only:
  - If level < target, level+1.
  - If level > target, level-1.
  - If equal, hold.
  - Level moves at most 1 per tick and never overflows or underflows (4-bit, 0..15).
- bright_max change mid-ramp:
  - The target changes immediately.
  - Level converges at 1 step/tick from its current value, with no jump.
  - Lowering bright_max below the current level ramps that level down.
- Input toggles mid-ramp:
  - The direction reverses on the next tick from the current level.
- busy:
  - busy <= OR over i of (level[i] != target[i]), registered.
  - busy is 0 when all channels have settled.
- Simultaneous step_tick and input change:
  - The level update uses the target computed from light_s in that same cycle.
- No handshake:
  - light_in is level-sensitive.
  - Pulses shorter than 2 cycles may be missed; this is accepted.

Optional Feature:
- Macro: LIGHT_INSTANT_OFF_EN.
- Defined:
  - When light_s[i] is 0, level[i] is forced to 0 on the next cycle, without waiting for step_tick.
  - Rising still fades at 1 step/tick.
  - bright_max decreases still ramp down at 1 step/tick.
- Undefined:
  - Symmetric fade in both directions, as described above.

Decomposition:
- Shared package light_pkg holds:
  - LEVEL_W = 4.
  - LEVEL_MAX = 15.
  - PWM_PERIOD = 15.
  - Typedef level_t (LEVEL_W-bit unsigned).
- Sub-module light_fade_chan, instantiated N_LED times. Each instance holds:
  - one level register;
  - the target mux;
  - the up/down step logic;
  - the PWM compare.
- pwm_cnt, the prescaler, the synchronizer and the busy OR stay in the top level and are shared by all channels.

Test Plan (STEP_DIV=4 overridden for all cases):
- Reset: assert rst mid-ramp with levels at 7 -> led_out=0 and busy=0 immediately (async); after release, all levels=0 and pwm_cnt restarts from 0.
- Fade up: bright_max=15, light_in 0x00->0x01 -> bit 0 reaches level 15 after 15 ticks (60 cycles ±4 plus sync); led_out[0] is then constantly 1; busy goes 1 then 0.
- Duty check: bright_max=5, light_in=0xFF settled -> every led_out bit is high exactly 5 of every 15 cycles, aligned to pwm_cnt 0..4.
- Reverse mid-ramp: light_in=0x80 ramps bit 7 to level 6, then drops to 0x00 -> level decreases 6,5,…,0 at 1/tick with no jump; busy=0 at the end.
- Ceiling change: all channels settled at 12, bright_max set to 3 -> levels step 12->3 in 9 ticks; a further change to 10 ramps back up by 7 ticks.
- LIGHT_INSTANT_OFF_EN defined: channels at level 15, light_in 0xFF->0x0F -> levels of bits 7..4 are 0 by 3 cycles after the input change (2 sync + 1); bits 3..0 stay at 15.

Source files
------------

// File: rtl/light_pkg.sv
// light_pkg: constants and types shared by the light_fader top and its channels.
//
// Contents:
//   LEVEL_W     width of a brightness level (4 bits, 0..15)
//   LEVEL_MAX   brightest level (15)
//   PWM_PERIOD  PWM frame length in clk100khz cycles (15)
//   level_t     unsigned LEVEL_W-bit brightness level
//   step_toward one-step move of a level toward a target, never past it
package light_pkg;

    localparam int LEVEL_W    = 4;
    localparam int LEVEL_MAX  = 15;
    localparam int PWM_PERIOD = 15;

    typedef logic [LEVEL_W-1:0] level_t;

    // Moves cur by one toward tgt. Because it only steps while cur != tgt,
    // it can never wrap past 0 or LEVEL_MAX.
    function automatic level_t step_toward(input level_t cur, input level_t tgt);
        if (cur < tgt) begin
            return cur + level_t'(1);
        end else if (cur > tgt) begin
            return cur - level_t'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/light_fade_chan.sv
// light_fade_chan: one LED channel of light_fader.
//
// Holds the channel's brightness level, chooses its target (bright_max
// when the synchronized input is on, 0 when off), steps the level by one
// toward the target on each step_tick, and compares the level against the
// shared PWM counter to produce a registered LED drive.
//
// Optional feature (macro LIGHT_INSTANT_OFF_EN): a channel whose
// synchronized input is 0 drops to level 0 on the next cycle instead of
// fading down.
//
// Ports:
//   clk100khz   system clock
//   rst         asynchronous active-high reset
//   light_s     synchronized on/off request for this channel
//   step_tick   one-cycle pulse that allows a level step
//   bright_max  global brightness ceiling
//   pwm_cnt     shared PWM frame counter, 0..PWM_PERIOD-1
//   led         registered PWM drive for this LED
//   differs     combinational: level has not yet reached target
module light_fade_chan
    import light_pkg::*;
(
    input  logic   clk100khz,
    input  logic   rst,
    input  logic   light_s,
    input  logic   step_tick,
    input  level_t bright_max,
    input  level_t pwm_cnt,
    output logic   led,
    output logic   differs
);

    level_t level;
    level_t target;

    // Target follows light_s and bright_max in the same cycle, so a tick that
    // coincides with an input change already uses the new target.
    assign target  = light_s ? bright_max : '0;
    assign differs = (level != target);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
`ifdef LIGHT_INSTANT_OFF_EN
            if (!light_s) begin
                level <= '0;
            end else if (step_tick) begin
                level <= step_toward(level, target);
            end
`else
            if (step_tick) begin
                level <= step_toward(level, target);
            end
`endif
            // pwm_cnt never reaches 15, so level 15 is always on and
            // level k is high for pwm_cnt = 0..k-1.
            led <= (level > pwm_cnt);
        end
    end

endmodule

// File: rtl/light_fader.sv
// light_fader: PWM fade stage between the LED pattern generator and the
// board LED pins.
//
// Each bit of light_in fades its LED up toward bright_max when 1 and down
// to 0 when 0, one brightness level per step_tick (every STEP_DIV cycles).
// Brightness is rendered as a 15-cycle PWM frame.
//
// Parameters:
//   N_LED      number of LED channels
//   STEP_DIV   clk100khz cycles per brightness step (must be >= 2)
//
// Optional feature: define LIGHT_INSTANT_OFF_EN to make channels switch off
// immediately (next cycle) instead of fading down when their input goes 0.
// Fading up and ceiling-driven ramps are unchanged.
//
// Ports:
//   clk100khz   100 kHz system clock
//   rst         asynchronous active-high reset, released on a clock edge
//   light_in    raw on/off pattern, asynchronous to fade timing
//   bright_max  global ceiling level 0..15, sampled every cycle
//   led_out     registered PWM LED drive
//   busy        registered, 1 while any channel level differs from target
module light_fader
    import light_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int STEP_DIV = 625
) (
    input  logic             clk100khz,
    input  logic             rst,
    input  logic [N_LED-1:0] light_in,
    input  logic [3:0]       bright_max,
    output logic [N_LED-1:0] led_out,
    output logic             busy
);

    localparam int PRESC_W = $clog2(STEP_DIV);

    logic [N_LED-1:0]   light_m;
    logic [N_LED-1:0]   light_s;
    level_t             pwm_cnt;
    logic [PRESC_W-1:0] presc;
    logic               step_tick;
    logic [N_LED-1:0]   differs;

    assign step_tick = (presc == PRESC_W'(STEP_DIV - 1));

    // NOTE: every flop here, synchronizer included, sits on the async reset
    // so the outputs are quiet as soon as rst rises, without waiting for a clock.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            light_m <= '0;
            light_s <= '0;
            pwm_cnt <= '0;
            presc   <= '0;
            busy    <= 1'b0;
        end else begin
            // Two-flop synchronizer; light_in has no timing relation to the fade.
            light_m <= light_in;
            light_s <= light_m;

            if (pwm_cnt == level_t'(PWM_PERIOD - 1)) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + level_t'(1);
            end

            if (step_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end

            busy <= |differs;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        light_fade_chan u_chan (
            .clk100khz  (clk100khz),
            .rst        (rst),
            .light_s    (light_s[i]),
            .step_tick  (step_tick),
            .bright_max (level_t'(bright_max)),
            .pwm_cnt    (pwm_cnt),
            .led        (led_out[i]),
            .differs    (differs[i])
        );
    end

endmodule

// File: tb/tb_light_fader.sv
// tb_light_fader: self-checking bench for light_fader with STEP_DIV = 4.
//
// The reference model works per clock edge counted from reset release:
// the PWM phase is edge mod 15, a step happens on edges where
// edge mod STEP_DIV == STEP_DIV-1, and the synchronized input seen at an
// edge is the light_in value sampled two edges earlier. Levels are plain
// integers that move one unit toward their target on step edges.
module tb_light_fader;

    localparam int N_LED    = 8;
    localparam int STEP_DIV = 4;
    localparam int PERIOD   = 15;

    logic             clk100khz = 1'b0;
    logic             rst;
    logic [N_LED-1:0] light_in;
    logic [3:0]       bright_max;
    logic [N_LED-1:0] led_out;
    logic             busy;

    always #5 clk100khz = ~clk100khz;

    light_fader #(
        .N_LED    (N_LED),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk100khz  (clk100khz),
        .rst        (rst),
        .light_in   (light_in),
        .bright_max (bright_max),
        .led_out    (led_out),
        .busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               edge_n;
    logic [N_LED-1:0] hist[$];
    int               lvl[N_LED];
    logic [N_LED-1:0] exp_led;
    logic             exp_busy;

    task automatic model_reset();
        hist.delete();
        edge_n   = 0;
        exp_led  = '0;
        exp_busy = 1'b0;
        for (int i = 0; i < N_LED; i++) lvl[i] = 0;
    endtask

    task automatic model_edge(input logic [N_LED-1:0] li, input int bm);
        logic [N_LED-1:0] ls;
        int phase;
        bit tick;
        int tgt;
        ls    = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        phase = edge_n % PERIOD;
        tick  = (edge_n % STEP_DIV) == STEP_DIV - 1;
        exp_busy = 1'b0;
        for (int i = 0; i < N_LED; i++) begin
            tgt = ls[i] ? bm : 0;
            exp_led[i] = (lvl[i] > phase);
            if (lvl[i] != tgt) exp_busy = 1'b1;
`ifdef LIGHT_INSTANT_OFF_EN
            if (!ls[i]) lvl[i] = 0;
            else if (tick && lvl[i] < tgt) lvl[i]++;
            else if (tick && lvl[i] > tgt) lvl[i]--;
`else
            if (tick && lvl[i] < tgt) lvl[i]++;
            else if (tick && lvl[i] > tgt) lvl[i]--;
`endif
        end
        hist.push_back(li);
        if (hist.size() > 4) void'(hist.pop_front());
        edge_n++;
    endtask

    // One clock: model consumes the inputs seen at this edge, then outputs are compared.
    task automatic cycle(input string tag);
        @(posedge clk100khz);
        model_edge(light_in, int'(bright_max));
        #1;
        check({tag, "_led"}, 32'(led_out), 32'(exp_led));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic run_until_level(input string tag, input int ch, input int want);
        int budget = 200;
        while (lvl[ch] != want && budget > 0) begin
            cycle(tag);
            budget--;
        end
        check({tag, "_reached"}, 32'(lvl[ch]), 32'(want));
    endtask

    // Assert rst away from the clock edge, check the async clear, release on a negedge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_async_led"}, 32'(led_out), 32'(0));
        check({tag, "_async_busy"}, 32'(busy), 32'(0));
        repeat (3) @(posedge clk100khz);
        @(negedge clk100khz);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[N_LED];
        bit saw_busy;

        rst        = 1'b1;
        light_in   = '0;
        bright_max = '0;
        model_reset();
        repeat (3) @(posedge clk100khz);
        @(negedge clk100khz);
        rst = 1'b0;

        // Idle after reset: everything dark and settled.
        run("idle", 6);
        check("idle_led", 32'(led_out), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));

        // Fade up bit 0 to full brightness.
        bright_max = 4'd15;
        light_in   = 8'h01;
        saw_busy   = 1'b0;
        for (int k = 0; k < 75; k++) begin
            cycle("fade_up");
            if (busy) saw_busy = 1'b1;
        end
        check("fade_up_busy_seen", 32'(saw_busy), 32'(1));
        for (int k = 0; k < PERIOD; k++) begin
            cycle("fade_up_full");
            check("fade_up_const_on", 32'(led_out), 32'(8'h01));
        end
        check("fade_up_settled", 32'(busy), 32'(0));

        // Reverse mid-ramp on bit 7.
        light_in = 8'h80;
        run_until_level("rev_up", 7, 6);
        light_in = 8'h00;
        run("rev_down", 90);
        check("rev_dark", 32'(led_out), 32'(0));
        check("rev_settled", 32'(busy), 32'(0));

        // Ceiling changes with all channels on.
        bright_max = 4'd12;
        light_in   = 8'hFF;
        run("ceil_12", 60);
        check("ceil_12_settled", 32'(busy), 32'(0));
        bright_max = 4'd3;
        run("ceil_3", 9 * STEP_DIV + 2);
        check("ceil_3_settled", 32'(busy), 32'(0));
        bright_max = 4'd10;
        run("ceil_10", 7 * STEP_DIV + 2);
        check("ceil_10_settled", 32'(busy), 32'(0));

        // Duty: level 5 is high exactly 5 of each 15 cycles, at PWM phases 0..4.
        bright_max = 4'd5;
        run("duty_settle", 40);
        for (int i = 0; i < N_LED; i++) cnt[i] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            cycle("duty");
            check("duty_align", 32'(led_out), (((edge_n - 1) % PERIOD) < 5) ? 32'hFF : 32'h00);
            for (int i = 0; i < N_LED; i++) cnt[i] += int'(led_out[i]);
        end
        for (int i = 0; i < N_LED; i++) check($sformatf("duty_b%0d", i), 32'(cnt[i]), 32'(5));

        // Upper nibble switched off from full brightness.
        bright_max = 4'd15;
        run("off_settle", 50);
        light_in = 8'h0F;
        run("off_sync", 4);
`ifdef LIGHT_INSTANT_OFF_EN
        for (int k = 0; k < PERIOD; k++) begin
            cycle("instant_off");
            check("instant_off_led", 32'(led_out), 32'(8'h0F));
        end
`else
        check("fade_off_busy", 32'(busy), 32'(1));
        run("fade_off", 70);
        check("fade_off_led", 32'(led_out), 32'(8'h0F));
`endif

        // Asynchronous reset in the middle of a ramp at level 7.
        do_reset("rst0");
        run("rst0_idle", 3);
        light_in = 8'hFF;
        run_until_level("mid_ramp", 0, 7);
        do_reset("rst_mid");
        light_in   = 8'h00;
        run("post_rst", 20);
        check("post_rst_busy", 32'(busy), 32'(0));

        // Randomized pattern and ceiling activity.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7, 0) == 0) light_in = N_LED'($urandom);
            if ($urandom_range(29, 0) == 0) bright_max = 4'($urandom);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
